spmv_fp_mul_pipe: RTL and testbench
===================================

# spmv_fp_mul_pipe

Parametrised, fully pipelined IEEE-754-style floating-point multiplier for the SpMV datapath. It replaces the fixed fp16 multiplier and adds:
- configurable exponent/mantissa widths
- correct normalisation and round-to-nearest-even
- special-value handling and exception flags
- a valid/ready handshake with backpressure
- a pass-through tag so the downstream accumulator can match each product to its row/column index

## Interface
Parameters:
- EXP_W, 5, exponent field width; BIAS = 2^(EXP_W-1)-1
- MAN_W, 10, stored mantissa width; word width W = 1+EXP_W+MAN_W
- TAG_W, 8, sideband tag width (row index), carried unchanged

Ports:
- i_clk  input  1  clock, all logic on rising edge
- i_rstn  input  1  reset; asynchronous, active-low
- i_valid  input  1  operand pair valid
- o_ready  output  1  block accepts operands this cycle
- i_vector  input  W  operand A (vector element)
- i_value  input  W  operand B (matrix value)
- i_tag  input  TAG_W  sideband, returned with result
- o_valid  output  1  result valid
- i_ready  input  1  downstream accepts result
- o_result  output  W  product
- o_tag  output  TAG_W  tag of this product
- o_flags  output  4  {invalid, overflow, underflow, inexact}

## Operation
Pipeline stages:
- S1: classify operands, compute sign = sA^sB, compute exponent sum eA+eB-BIAS in EXP_W+2 signed bits, compute full product P = {1,mA}*{1,mB} (2*MAN_W+2 bits).
- S2: normalise and round.
  - If P MSB is 1: take mantissa from the bits below the MSB and add 1 to the exponent. Otherwise shift left by one.
  - Guard = next bit below the kept mantissa; sticky = OR of all remaining bits.
  - Round to nearest even: increment when guard & (sticky | lsb).
  - A rounding carry out of the mantissa renormalises: mantissa = 0, exponent +1.
  - inexact = guard | sticky.
- S3: final exponent checks, special-value override, pack the word and drive flags.

Operand classes:
- exp==0 → zero. Subnormal inputs are flushed to zero and do not raise a flag.
- exp all ones with mantissa 0 → infinity.
- exp all ones with mantissa ≠0 → NaN.

Result rules (highest priority first):
- Any NaN operand, or inf×zero → canonical qNaN: sign 0, exp all ones, mantissa MSB=1, rest 0. invalid=1.
- inf×(inf or normal) → inf with the XOR sign; no flags.
- zero×(zero or normal) → zero with the XOR sign; no flags.
- Normal×normal with final biased exponent ≥ 2^EXP_W-1 → signed inf; overflow=1, inexact=1.
- Normal×normal with final biased exponent ≤ 0 → signed zero (no subnormal outputs); underflow=1, inexact=1.
- Otherwise → packed normal result; inexact from rounding.

Flags apply only to the result they accompany; they are not sticky.

## Timing
- Reset (i_rstn low, asynchronous): all stage valids, o_valid, o_result, o_tag and o_flags go to 0. Datapath-internal registers need no reset.
- Global advance enable en = !o_valid | i_ready. o_ready = en, combinational.
- An input transfer happens on a rising edge with i_valid & o_ready. An output transfer happens with o_valid & i_ready.
- Latency is exactly 3 cycles from input transfer to o_valid when no backpressure is applied. Throughput is 1 result per cycle.
- When o_valid=1 and i_ready=0, every stage freezes.
  - o_result, o_tag and o_flags must hold stable until the transfer.
  - Bubbles inside the pipeline are not compressed.
- Simultaneous input and output transfer in the same cycle is legal and must lose nothing.
- i_valid while o_ready=0 is ignored; the source must hold its data.
- Reset asserted mid-operation discards all in-flight products. After release, the first result appears 3 cycles after the first accepted input.
- Ordering: results and tags leave in acceptance order.

## Test plan
All vectors use fp16 defaults, TAG_W=8.
- Basic: 0x3C00×0x4000 (tag 0x11) → 0x4000, tag 0x11, flags 0, o_valid exactly 3 cycles after acceptance. Also 0x3E00×0x3E00 → 0x4080. Also 0xBC00×0x4000 → 0xC000.
- Rounding:
  - 0x3C01×0x3C01 → 0x3C02, inexact=1.
  - Tie rounds to even: 0x3C01×0x3E00 → 0x3E02 (inexact); 0x3C03×0x3E00 → 0x3E04 (inexact).
- Exceptions:
  - 0x7BFF×0x4000 → 0x7C00, overflow+inexact.
  - 0x0400×0x3800 → 0x0000, underflow+inexact.
  - 0x7C00×0x0000 → 0x7E00, invalid.
  - 0x7E01×0x3C00 → 0x7E00, invalid.
  - 0xFC00×0x3C00 → 0xFC00, no flags.
  - 0x0001×0x3C00 → 0x0000 (subnormal flushed), no flags.
- Backpressure: stream 8 tagged products with i_ready toggling pseudo-randomly.
  - Every result must match the reference model, in order, with no drops or duplicates.
  - Outputs must stay stable while o_valid&!i_ready.
  - o_ready must equal !o_valid|i_ready every cycle.
- Throughput: i_ready=1 with i_valid held high for 20 cycles → 20 consecutive o_valid cycles starting at cycle 3.
- Reset mid-stream: assert i_rstn=0 with 3 products in flight.
  - All outputs must read 0 immediately.
  - No stale result may appear after release.
  - A new product after release completes with latency 3.

Source files
------------

// File: rtl/spmv_fp_mul_pipe.sv
// Three-stage IEEE-754-style multiplier for the SpMV datapath. Normalises and
// rounds to nearest even, handles special values, carries a tag and stalls on backpressure.
module spmv_fp_mul_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int TAG_W = 8,
  localparam int W    = 1 + EXP_W + MAN_W
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [W-1:0]     i_vector,
  input  logic [W-1:0]     i_value,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [W-1:0]     o_result,
  output logic [TAG_W-1:0] o_tag,
  output logic [3:0]       o_flags
);

  localparam int PW = 2 * MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS_E = EW'(2 ** (EXP_W - 1) - 1);
  localparam logic signed [EW-1:0] EMAX_E = EW'(2 ** EXP_W - 1);
  localparam logic signed [EW-1:0] ONE_E  = EW'(1);
  localparam logic signed [EW-1:0] ZERO_E = '0;

  // Returns {carry, mantissa}; a carry means the mantissa wrapped to zero.
  function automatic logic [MAN_W:0] round_rne(input logic [MAN_W-1:0] man,
                                               input logic guard, input logic sticky);
    logic inc;
    inc = guard & (sticky | man[0]);
    return {1'b0, man} + {{MAN_W{1'b0}}, inc};
  endfunction

  // Returns {flags, word} with special-value priority and exponent saturation.
  function automatic logic [W+3:0] pack_result(input logic sign, input logic signed [EW-1:0] exp,
                                               input logic [MAN_W-1:0] man, input logic nan,
                                               input logic inf, input logic zero,
                                               input logic inexact);
    if (nan)
      return {4'b1000, 1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    else if (inf)
      return {4'b0000, sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (zero)
      return {4'b0000, sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
    else if (exp >= EMAX_E)
      return {4'b0110, sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (exp <= ZERO_E)
      return {4'b0011, sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
    else
      return {3'b000, inexact, sign, exp[EXP_W-1:0], man};
  endfunction

  logic en;
  assign en      = !o_valid | i_ready;
  assign o_ready = en;

  // Stage 1: classify, sign, exponent sum, full significand product
  logic                    sign_a, sign_b;
  logic [EXP_W-1:0]        exp_a, exp_b;
  logic [MAN_W-1:0]        man_a, man_b;
  logic                    zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  logic signed [EW-1:0]    exp_sum;
  logic [PW-1:0]           prod;

  assign sign_a = i_vector[W-1];
  assign sign_b = i_value[W-1];
  assign exp_a  = i_vector[W-2 -: EXP_W];
  assign exp_b  = i_value[W-2 -: EXP_W];
  assign man_a  = i_vector[MAN_W-1:0];
  assign man_b  = i_value[MAN_W-1:0];
  assign zero_a = (exp_a == '0);
  assign zero_b = (exp_b == '0);
  assign inf_a  = (&exp_a) && (man_a == '0);
  assign inf_b  = (&exp_b) && (man_b == '0);
  assign nan_a  = (&exp_a) && (man_a != '0);
  assign nan_b  = (&exp_b) && (man_b != '0);
  assign exp_sum = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_E;
  assign prod    = {1'b1, man_a} * {1'b1, man_b};

  logic                 vld_p1, sign_p1, nan_p1, inf_p1, zero_p1;
  logic signed [EW-1:0] exp_p1;
  logic [PW-1:0]        prod_p1;
  logic [TAG_W-1:0]     tag_p1;

  always_ff @(posedge i_clk) begin
    if (en && i_valid) begin
      sign_p1 <= sign_a ^ sign_b;
      exp_p1  <= exp_sum;
      prod_p1 <= prod;
      nan_p1  <= nan_a | nan_b | (inf_a & zero_b) | (zero_a & inf_b);
      inf_p1  <= inf_a | inf_b;
      zero_p1 <= zero_a | zero_b;
      tag_p1  <= i_tag;
    end
  end

  // Stage 2: normalise, guard/sticky, round to nearest even
  logic [PW-2:0]        prod_n;
  logic signed [EW-1:0] exp_n;
  logic                 guard, sticky;
  logic [MAN_W:0]       rnd;

  assign prod_n = prod_p1[PW-1] ? prod_p1[PW-2:0] : {prod_p1[PW-3:0], 1'b0};
  assign exp_n  = prod_p1[PW-1] ? exp_p1 + ONE_E : exp_p1;
  assign guard  = prod_n[PW-2-MAN_W];
  assign sticky = |prod_n[PW-3-MAN_W:0];
  assign rnd    = round_rne(prod_n[PW-2 -: MAN_W], guard, sticky);

  logic                 vld_p2, sign_p2, nan_p2, inf_p2, zero_p2, inexact_p2;
  logic signed [EW-1:0] exp_p2;
  logic [MAN_W-1:0]     man_p2;
  logic [TAG_W-1:0]     tag_p2;

  always_ff @(posedge i_clk) begin
    if (en && vld_p1) begin
      sign_p2    <= sign_p1;
      exp_p2     <= rnd[MAN_W] ? exp_n + ONE_E : exp_n;
      man_p2     <= rnd[MAN_W-1:0];
      inexact_p2 <= guard | sticky;
      nan_p2     <= nan_p1;
      inf_p2     <= inf_p1;
      zero_p2    <= zero_p1;
      tag_p2     <= tag_p1;
    end
  end

  // Stage 3: exponent range checks, special override, pack
  logic [W+3:0] packed_p2;
  assign packed_p2 = pack_result(sign_p2, exp_p2, man_p2, nan_p2, inf_p2, zero_p2, inexact_p2);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      o_valid  <= 1'b0;
      o_result <= '0;
      o_tag    <= '0;
      o_flags  <= '0;
    end else if (en) begin
      vld_p1  <= i_valid;
      vld_p2  <= vld_p1;
      o_valid <= vld_p2;
      if (vld_p2) begin
        o_result <= packed_p2[W-1:0];
        o_flags  <= packed_p2[W+3:W];
        o_tag    <= tag_p2;
      end
    end
  end

endmodule

// File: tb/tb_spmv_fp_mul_pipe.sv
// Directed bench for spmv_fp_mul_pipe (fp16): arithmetic, specials, backpressure,
// throughput and mid-stream reset, with hand-computed expected values.
module tb_spmv_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_valid, i_ready;
  logic        o_ready, o_valid;
  logic [15:0] vec, val, rslt;
  logic [7:0]  tag_in, otag;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spmv_fp_mul_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(8)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_valid(i_valid), .o_ready(o_ready),
    .i_vector(vec), .i_value(val), .i_tag(tag_in), .o_valid(o_valid),
    .i_ready(i_ready), .o_result(rslt), .o_tag(otag), .o_flags(flags)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // One isolated product: accept, measure latency, check result/tag/flags.
  task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic [7:0] tag, input logic [15:0] er, input logic [3:0] ef);
    int lat;
    @(negedge clk);
    vec = a; val = b; tag_in = tag; i_valid = 1'b1; i_ready = 1'b1;
    #1 chk({name, "_ordy"}, o_ready, 1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    i_valid = 1'b0;
    while (!o_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({name, "_lat"}, lat, 3);
    chk({name, "_vld"}, o_valid, 1);
    chk({name, "_res"}, rslt, er);
    chk({name, "_tag"}, otag, tag);
    chk({name, "_flg"}, flags, ef);
  endtask

  logic [15:0] ta [8];
  logic [15:0] tb [8];
  logic [15:0] tr [8];
  logic [3:0]  tf [8];
  int          sent, recv, cyc;
  logic        hold;
  logic [15:0] h_res;
  logic [7:0]  h_tag;
  logic [3:0]  h_flg;

  initial begin
    ta[0] = 16'h3C00; tb[0] = 16'h4000; tr[0] = 16'h4000; tf[0] = 4'h0;
    ta[1] = 16'h3E00; tb[1] = 16'h3E00; tr[1] = 16'h4080; tf[1] = 4'h0;
    ta[2] = 16'h3C01; tb[2] = 16'h3C01; tr[2] = 16'h3C02; tf[2] = 4'h1;
    ta[3] = 16'h3C01; tb[3] = 16'h3E00; tr[3] = 16'h3E02; tf[3] = 4'h1;
    ta[4] = 16'h7BFF; tb[4] = 16'h4000; tr[4] = 16'h7C00; tf[4] = 4'h6;
    ta[5] = 16'h0400; tb[5] = 16'h3800; tr[5] = 16'h0000; tf[5] = 4'h3;
    ta[6] = 16'h7C00; tb[6] = 16'h0000; tr[6] = 16'h7E00; tf[6] = 4'h8;
    ta[7] = 16'hBC00; tb[7] = 16'h4000; tr[7] = 16'hC000; tf[7] = 4'h0;

    rstn = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    vec = '0; val = '0; tag_in = '0;
    @(posedge clk);
    #1;
    chk("rst_vld", o_valid, 0);
    chk("rst_res", rslt, 0);
    chk("rst_tag", otag, 0);
    chk("rst_flg", flags, 0);
    @(negedge clk);
    rstn = 1'b1;

    do_op("basic1",  16'h3C00, 16'h4000, 8'h11, 16'h4000, 4'h0);
    do_op("basic2",  16'h3E00, 16'h3E00, 8'h12, 16'h4080, 4'h0);
    do_op("basic3",  16'hBC00, 16'h4000, 8'h13, 16'hC000, 4'h0);
    do_op("rnd1",    16'h3C01, 16'h3C01, 8'h21, 16'h3C02, 4'h1);
    do_op("tie_up",  16'h3C01, 16'h3E00, 8'h22, 16'h3E02, 4'h1);
    do_op("tie_evn", 16'h3C03, 16'h3E00, 8'h23, 16'h3E04, 4'h1);
    do_op("ovf",     16'h7BFF, 16'h4000, 8'h31, 16'h7C00, 4'h6);
    do_op("unf",     16'h0400, 16'h3800, 8'h32, 16'h0000, 4'h3);
    do_op("infzero", 16'h7C00, 16'h0000, 8'h33, 16'h7E00, 4'h8);
    do_op("nan",     16'h7E01, 16'h3C00, 8'h34, 16'h7E00, 4'h8);
    do_op("neginf",  16'hFC00, 16'h3C00, 8'h35, 16'hFC00, 4'h0);
    do_op("subnorm", 16'h0001, 16'h3C00, 8'h36, 16'h0000, 4'h0);

    // Backpressure stream
    sent = 0; recv = 0; cyc = 0; hold = 1'b0;
    while (recv < 8 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        chk("bp_hold_res", rslt, h_res);
        chk("bp_hold_tag", otag, h_tag);
        chk("bp_hold_flg", flags, h_flg);
      end
      i_ready = 1'($urandom_range(0, 1));
      if (sent < 8) begin
        i_valid = 1'b1; vec = ta[sent]; val = tb[sent]; tag_in = 8'hA0 + 8'(sent);
      end else begin
        i_valid = 1'b0;
      end
      #1;
      chk("bp_ordy", o_ready, !o_valid | i_ready);
      hold = o_valid && !i_ready;
      h_res = rslt; h_tag = otag; h_flg = flags;
      if (o_valid && i_ready) begin
        chk("bp_res", rslt, tr[recv]);
        chk("bp_tag", otag, 8'hA0 + 8'(recv));
        chk("bp_flg", flags, tf[recv]);
        recv++;
      end
      if (i_valid && o_ready) sent++;
    end
    chk("bp_count", recv, 8);
    @(negedge clk);
    i_valid = 1'b0; i_ready = 1'b1;
    #1 chk("bp_nodup", o_valid, 0);
    repeat (3) @(negedge clk);

    // Throughput: 20 back-to-back products
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      i_ready = 1'b1; i_valid = (c < 20);
      vec = 16'h3C00; val = 16'h4000; tag_in = c[7:0];
      #1;
      chk("tp_vld", o_valid, (c >= 3 && c < 23));
      if (c >= 3 && c < 23) chk("tp_tag", otag, c - 3);
    end

    // Reset with three products in flight
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      i_valid = 1'b1; i_ready = 1'b1; vec = 16'h3C00; val = 16'h4000; tag_in = 8'h51 + 8'(k);
    end
    @(negedge clk);
    i_valid = 1'b0;
    #1 chk("rs_pre_tag", otag, 8'h51);
    #1 rstn = 1'b0;
    #1;
    chk("rs_vld", o_valid, 0);
    chk("rs_res", rslt, 0);
    chk("rs_tag", otag, 0);
    chk("rs_flg", flags, 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rs_stale", o_valid, 0);
    end
    do_op("rs_new", 16'h3E00, 16'h3E00, 8'h77, 16'h4080, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
